// File: rtl/pipe_pkg.sv
// Shared types and widths for the correction pipe and its feeder.
package pipe_pkg;
    localparam int DATA_W = 16;
    localparam int CF_W   = 2;

    typedef enum logic [1:0] {RUN, DRAIN, APPLY} feeder_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d0;
    } pair_t;
endpackage

// File: rtl/pipe_feeder_fifo.sv
// Synchronous FIFO of sample pairs; pointers carry an extra wrap bit so full/empty need no flag.
module pipe_feeder_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wr_data,
    output logic [W-1:0]           rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/pipe_feeder.sv
// Feeds buffered sample pairs into the correction pipe and sequences CF changes
// so the factor only moves once the FIFO and the pipe are both empty.
module pipe_feeder
    import pipe_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int CF_RESET = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_W-1:0]      s_data0,
    input  logic [DATA_W-1:0]      s_data1,
    input  logic                   hold,
    input  logic                   cfg_we,
    input  logic [CF_W-1:0]        cfg_cf,
    output logic                   cfg_busy,
    output logic                   o_en,
    output logic [CF_W-1:0]        o_cf,
    output logic [DATA_W-1:0]      o_data0,
    output logic [DATA_W-1:0]      o_data1,
    output logic                   o_pipe_vld,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int VLD_STAGES = 2;

    feeder_state_t         state;
    logic [CF_W-1:0]       pend_cf;
    logic [VLD_STAGES-1:0] vld_pipe;
    pair_t                 wr_pair, rd_pair;
    logic                  push, pop, empty, full, pipe_idle;

    // Gate with rst_n so the source never sees ready while held in reset.
    assign s_ready    = rst_n && (state == RUN) && !full;
    assign push       = s_valid && s_ready;
    assign pop        = !empty && !hold && (state != APPLY);
    assign pipe_idle  = empty && !o_en && (vld_pipe == '0);
    assign cfg_busy   = (state != RUN);
    assign o_pipe_vld = vld_pipe[VLD_STAGES-1];
    assign wr_pair    = '{d1: s_data1, d0: s_data0};

    pipe_feeder_fifo #(.W($bits(pair_t)), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_pair),
        .rd_data (rd_pair),
        .count   (o_count),
        .empty   (empty),
        .full    (full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            pend_cf <= CF_W'(CF_RESET);
            o_cf    <= CF_W'(CF_RESET);
        end else begin
            case (state)
                RUN: if (cfg_we) begin
                    pend_cf <= cfg_cf;
                    state   <= DRAIN;
                end
                DRAIN: begin
                    if (cfg_we)    pend_cf <= cfg_cf;
                    if (pipe_idle) state   <= APPLY;
                end
                APPLY: begin
                    o_cf <= pend_cf;
                    if (cfg_we) begin
                        pend_cf <= cfg_cf;
                        state   <= DRAIN;
                    end else begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Issue stage plus the delay line that lines o_pipe_vld up with the pipe's registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_en     <= 1'b0;
            o_data0  <= '0;
            o_data1  <= '0;
            vld_pipe <= '0;
        end else begin
            o_en     <= pop;
            vld_pipe <= {vld_pipe[VLD_STAGES-2:0], o_en};
            if (pop) begin
                o_data0 <= rd_pair.d0;
                o_data1 <= rd_pair.d1;
            end
        end
    end
endmodule

// File: tb/tb_pipe_feeder.sv
// Bench for pipe_feeder: queue/timestamp reference model, directed scenarios and a random soak.
module tb_pipe_feeder;
    import pipe_pkg::*;

    localparam int DEPTH    = 4;
    localparam int CF_RESET = 1;
    localparam int CW       = $clog2(DEPTH) + 1;
    localparam int M_RUN = 0, M_DRAIN = 1, M_APPLY = 2;

    logic              clk = 0, rst_n = 0, s_valid = 0, hold = 0, cfg_we = 0;
    logic [DATA_W-1:0] s_data0 = '0, s_data1 = '0;
    logic [CF_W-1:0]   cfg_cf = '0;
    logic              s_ready, cfg_busy, o_en, o_pipe_vld;
    logic [CF_W-1:0]   o_cf;
    logic [DATA_W-1:0] o_data0, o_data1;
    logic [CW-1:0]     o_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_feeder #(.DEPTH(DEPTH), .CF_RESET(CF_RESET)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data0(s_data0), .s_data1(s_data1), .hold(hold), .cfg_we(cfg_we),
        .cfg_cf(cfg_cf), .cfg_busy(cfg_busy), .o_en(o_en), .o_cf(o_cf),
        .o_data0(o_data0), .o_data1(o_data1), .o_pipe_vld(o_pipe_vld), .o_count(o_count)
    );

    // Reference model: FIFO as a queue, in-flight pairs as the edge index at which
    // their pipe valid is due (issue edge + 2).
    logic [31:0]       mq[$];
    int                due[$];
    int                m_state, m_cyc;
    logic [CF_W-1:0]   m_pend, m_cf;
    logic              m_en;
    logic [DATA_W-1:0] m_d0, m_d1;
    bit                m_push;

    function automatic bit due_at(int t);
        foreach (due[i]) if (due[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit inflight();
        foreach (due[i]) if (due[i] >= m_cyc) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_rdy();
        return rst_n && m_state == M_RUN && mq.size() < DEPTH;
    endfunction

    function automatic logic [40:0] dut_vec();
        return {s_ready, cfg_busy, o_en, o_cf, o_pipe_vld, o_count, o_data1, o_data0};
    endfunction

    function automatic logic [40:0] mdl_vec();
        return {m_rdy(), m_state != M_RUN, m_en, m_cf, due_at(m_cyc), CW'(mq.size()), m_d1, m_d0};
    endfunction

    task automatic mdl_reset();
        mq.delete();
        due.delete();
        m_state = M_RUN;
        m_pend  = CF_W'(CF_RESET);
        m_cf    = CF_W'(CF_RESET);
        m_en    = 1'b0;
        m_d0    = '0;
        m_d1    = '0;
        m_push  = 1'b0;
    endtask

    task automatic step();
        bit          rdy, pop, idle;
        logic [31:0] h;
        @(posedge clk);
        if (rst_n) begin
            rdy    = m_rdy();
            m_push = s_valid && rdy;
            pop    = mq.size() > 0 && !hold && m_state != M_APPLY;
            idle   = mq.size() == 0 && !inflight();
            case (m_state)
                M_RUN: if (cfg_we) begin m_pend = cfg_cf; m_state = M_DRAIN; end
                M_DRAIN: begin
                    if (cfg_we) m_pend = cfg_cf;
                    if (idle) m_state = M_APPLY;
                end
                default: begin
                    m_cf = m_pend;
                    if (cfg_we) begin m_pend = cfg_cf; m_state = M_DRAIN; end
                    else m_state = M_RUN;
                end
            endcase
            m_cyc++;
            m_en = pop;
            if (pop) begin
                h    = mq.pop_front();
                m_d0 = h[15:0];
                m_d1 = h[31:16];
                due.push_back(m_cyc + 2);
            end
            if (m_push) mq.push_back({s_data1, s_data0});
            while (due.size() > 0 && due[0] < m_cyc) void'(due.pop_front());
        end
        #1;
    endtask

    task automatic set_pair(input logic v, input logic [15:0] d0, input logic [15:0] d1);
        s_valid = v;
        s_data0 = d0;
        s_data1 = d1;
    endtask

    task automatic test_reset();
        mdl_reset();
        m_cyc = 0;
        #12;
        total++;
        if (dut_vec() !== mdl_vec()) begin
            bad++; $display("FAIL reset_state got=%h exp=%h", dut_vec(), mdl_vec());
        end
        total++;
        if (o_cf !== CF_W'(CF_RESET) || s_ready !== 1'b0) begin
            bad++; $display("FAIL reset_cf_ready got cf=%0d rdy=%b exp cf=%0d rdy=0", o_cf, s_ready, CF_RESET);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int en_i = -1, vld_i = -1, vld_n = 0;
        set_pair(1'b1, 16'h0003, 16'h0005);
        step();
        set_pair(1'b0, '0, '0);
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (dut_vec() !== mdl_vec()) begin
                bad++; $display("FAIL single cyc%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
            end
            if (o_en) en_i = i;
            if (o_en && (o_data0 !== 16'h0003 || o_data1 !== 16'h0005)) en_i = -2;
            if (o_pipe_vld) begin vld_i = i; vld_n++; end
        end
        total++;
        if (en_i != 0 || vld_i != 2 || vld_n != 1) begin
            bad++; $display("FAIL single_latency got en=%0d vld=%0d n=%0d exp en=0 vld=2 n=1", en_i, vld_i, vld_n);
        end
    endtask

    task automatic test_burst();
        logic [31:0] pairs[6];
        int idx = 0;
        foreach (pairs[i]) pairs[i] = $urandom;
        hold = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 8) begin
                total++;
                if (o_count !== CW'(4) || s_ready !== 1'b0) begin
                    bad++; $display("FAIL burst_full got cnt=%0d rdy=%b exp cnt=4 rdy=0", o_count, s_ready);
                end
                hold = 1'b0;
            end
            if (idx < 6) set_pair(1'b1, pairs[idx][15:0], pairs[idx][31:16]);
            else set_pair(1'b0, '0, '0);
            step();
            if (m_push) idx++;
            total++;
            if (dut_vec() !== mdl_vec()) begin
                bad++; $display("FAIL burst cyc%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_cfg_drain();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_pair(1'b1, 16'($urandom), 16'($urandom));
            step();
        end
        set_pair(1'b0, '0, '0);
        cfg_we = 1'b1;
        cfg_cf = 2'd3;
        step();
        cfg_we = 1'b0;
        hold   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (dut_vec() !== mdl_vec()) begin
                bad++; $display("FAIL cfg_drain cyc%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
            end
        end
        total++;
        if (o_cf !== 2'd3 || cfg_busy !== 1'b0) begin
            bad++; $display("FAIL cfg_drain_end got cf=%0d busy=%b exp cf=3 busy=0", o_cf, cfg_busy);
        end
    endtask

    task automatic test_double_cfg();
        int saw_two = 0;
        hold = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_pair(1'b1, 16'($urandom), 16'($urandom));
            step();
        end
        set_pair(1'b0, '0, '0);
        cfg_we = 1'b1;
        cfg_cf = 2'd2;
        step();
        cfg_cf = 2'd3;
        step();
        cfg_we = 1'b0;
        hold   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (o_cf == 2'd2) saw_two++;
            total++;
            if (dut_vec() !== mdl_vec()) begin
                bad++; $display("FAIL double_cfg cyc%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
            end
        end
        total++;
        if (saw_two != 0 || o_cf !== 2'd3) begin
            bad++; $display("FAIL double_cfg_cf got two=%0d cf=%0d exp two=0 cf=3", saw_two, o_cf);
        end
    endtask

    task automatic test_push_and_cfg();
        set_pair(1'b1, 16'($urandom), 16'($urandom));
        cfg_we = 1'b1;
        cfg_cf = 2'd0;
        step();
        set_pair(1'b0, '0, '0);
        cfg_we = 1'b0;
        total++;
        if (o_count !== CW'(1) || cfg_busy !== 1'b1) begin
            bad++; $display("FAIL push_cfg_accept got cnt=%0d busy=%b exp cnt=1 busy=1", o_count, cfg_busy);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            total++;
            if (dut_vec() !== mdl_vec()) begin
                bad++; $display("FAIL push_cfg cyc%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_pair(1'($urandom), 16'($urandom), 16'($urandom));
            hold   = ($urandom_range(0, 3) == 0);
            cfg_we = ($urandom_range(0, 31) == 0);
            cfg_cf = 2'($urandom);
            step();
            total++;
            if (dut_vec() !== mdl_vec()) begin
                bad++; $display("FAIL random cyc%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
            end
        end
        set_pair(1'b0, '0, '0);
        hold   = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic test_async_reset();
        cfg_we = 1'b1;
        cfg_cf = 2'd2;
        step();
        cfg_we = 1'b0;
        for (int i = 0; i < 12; i++) step();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_pair(1'b1, 16'($urandom), 16'($urandom));
            step();
        end
        hold = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_pair(1'b1, 16'($urandom), 16'($urandom));
            step();
        end
        set_pair(1'b0, '0, '0);
        total++;
        if (dut_vec() !== mdl_vec() || o_count !== CW'(3) || o_cf !== 2'd2) begin
            bad++; $display("FAIL pre_reset got=%h exp=%h", dut_vec(), mdl_vec());
        end
        #2;
        rst_n = 1'b0;
        mdl_reset();
        #1;
        total++;
        if (dut_vec() !== mdl_vec()) begin
            bad++; $display("FAIL async_reset got=%h exp=%h", dut_vec(), mdl_vec());
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (dut_vec() !== mdl_vec() || o_count !== CW'(0) || o_cf !== CF_W'(CF_RESET)) begin
                bad++; $display("FAIL post_reset cyc%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_cfg_drain();
        test_double_cfg();
        test_push_and_cfg();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
